// File: rtl/branch_resolve_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl_pkg
// Shared records, FSM encoding and helpers for the branch resolve controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package branch_resolve_ctrl_pkg;

   localparam logic [31:0] PC_INC = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } pred_rec_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } upd_rec_t;

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } brc_state_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/branch_resolve_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// brc_fifo
// Synchronous FIFO with synchronous clear; DEPTH must be a power of 2, >= 2.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module brc_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             i_clear,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);

   localparam int c_AW = $clog2(DEPTH);

   logic [c_AW:0]      r_wr_ptr;
   logic [c_AW:0]      r_rd_ptr;
   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic               w_do_push;
   logic               w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign w_do_pop  = i_pop && !o_empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_dout    = r_mem[r_rd_ptr[c_AW-1:0]];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_din;
            r_wr_ptr                  <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl
// Compares fetch predictions with decode outcomes, issues flush/redirect and
// queues predictor training updates. Optional: BRC_PERF_COUNTERS_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_resolve_ctrl
   import branch_resolve_ctrl_pkg::*;
#(
   parameter int DEPTH          = 4,
   parameter int RECOVER_CYCLES = 2,
   parameter int UBUF_DEPTH     = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        pred_valid,
   input  logic [31:0] pred_pc,
   input  logic        pred_taken,
   input  logic [31:0] pred_target,
   input  logic        id_valid,
   input  logic        id_freeze,
   input  logic [31:0] id_pc,
   input  logic        id_is_branch,
   input  logic        id_taken,
   input  logic [31:0] id_target,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        upd_valid,
   input  logic        upd_ready,
   output logic [31:0] upd_pc,
   output logic [31:0] upd_target,
   output logic        upd_taken,
   output logic        stall,
   output logic        q_full,
   output logic        sync_err
`ifdef BRC_PERF_COUNTERS_EN
   ,
   output logic [31:0] perf_branches,
   output logic [31:0] perf_mispredicts,
   output logic [31:0] perf_recover_cycles
`endif
);

   localparam int c_CNT_W = (RECOVER_CYCLES > 0) ? $clog2(RECOVER_CYCLES + 1) : 1;

   brc_state_t          r_state;
   logic [c_CNT_W-1:0]  r_cnt;
   logic                r_flush;
   logic [31:0]         r_redirect_pc;
   logic                r_sync_err;

   pred_rec_t           w_pred_in;
   pred_rec_t           w_q_dout;
   pred_rec_t           w_head;
   logic                w_q_empty;
   logic                w_q_full;
   upd_rec_t            w_u_din;
   upd_rec_t            w_u_dout;
   logic                w_u_empty;
   logic                w_u_full;
   logic                w_push;
   logic                w_resolve;
   logic                w_pc_mismatch;
   logic                w_mispredict;
   logic [31:0]         w_redirect;

   assign w_push    = pred_valid && !w_q_full && (r_state == RUN);
   assign w_resolve = id_valid && !id_freeze && (r_state == RUN);

   assign w_pred_in = '{pc: pred_pc, taken: pred_taken, target: pred_target};
   // An empty queue resolves against a not-taken record at the decode PC.
   assign w_head    = w_q_empty ? '{pc: id_pc, taken: 1'b0, target: 32'd0} : w_q_dout;

   assign w_pc_mismatch = (w_head.pc != id_pc);
   assign w_mispredict  = w_resolve &&
                          (w_pc_mismatch ||
                           (id_is_branch && (w_head.taken != id_taken)) ||
                           (id_is_branch && id_taken && (w_head.target != id_target)) ||
                           (!id_is_branch && w_head.taken));
   assign w_redirect    = (id_taken && id_is_branch) ? id_target : id_pc + PC_INC;

   brc_fifo #(
      .WIDTH ($bits(pred_rec_t)),
      .DEPTH (DEPTH)
   ) u_pred_q (
      .CLK     (CLK),
      .RESET   (RESET),
      .i_clear (w_mispredict),
      .i_push  (w_push),
      .i_pop   (w_resolve),
      .i_din   (w_pred_in),
      .o_dout  (w_q_dout),
      .o_full  (w_q_full),
      .o_empty (w_q_empty)
   );

   assign w_u_din = '{pc: id_pc, taken: id_taken, target: id_target};

   brc_fifo #(
      .WIDTH ($bits(upd_rec_t)),
      .DEPTH (UBUF_DEPTH)
   ) u_upd_buf (
      .CLK     (CLK),
      .RESET   (RESET),
      .i_clear (1'b0),
      .i_push  (w_resolve && id_is_branch),
      .i_pop   (upd_valid && upd_ready),
      .i_din   (w_u_din),
      .o_dout  (w_u_dout),
      .o_full  (w_u_full),
      .o_empty (w_u_empty)
   );

   assign upd_valid      = !w_u_empty;
   assign upd_pc         = w_u_dout.pc;
   assign upd_taken      = w_u_dout.taken;
   assign upd_target     = w_u_dout.target;
   assign stall          = w_u_full && !upd_ready;
   assign q_full         = w_q_full;
   assign flush          = r_flush;
   assign redirect_valid = r_flush;
   assign redirect_pc    = r_redirect_pc;
   assign sync_err       = r_sync_err;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state       <= RUN;
         r_cnt         <= '0;
         r_flush       <= 1'b0;
         r_redirect_pc <= '0;
         r_sync_err    <= 1'b0;
      end else begin
         r_flush <= w_mispredict;
         if (w_mispredict) begin
            r_redirect_pc <= w_redirect;
         end
         if (w_resolve && w_pc_mismatch) begin
            r_sync_err <= 1'b1;
         end
         case (r_state)
            RUN: begin
               if (w_mispredict) begin
                  r_state <= RECOVER;
                  r_cnt   <= c_CNT_W'(RECOVER_CYCLES);
               end
            end
            RECOVER: begin
               // Leaving on the last count keeps RECOVER exactly RECOVER_CYCLES long.
               if (r_cnt <= c_CNT_W'(1)) begin
                  r_state <= RUN;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt - c_CNT_W'(1);
               end
            end
            default: begin
               r_state <= RUN;
               r_cnt   <= '0;
            end
         endcase
      end
   end

`ifdef BRC_PERF_COUNTERS_EN
   logic [31:0] r_perf_branches;
   logic [31:0] r_perf_mispredicts;
   logic [31:0] r_perf_recover_cycles;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_perf_branches       <= '0;
         r_perf_mispredicts    <= '0;
         r_perf_recover_cycles <= '0;
      end else begin
         if (w_resolve && id_is_branch) begin
            r_perf_branches <= sat_inc(r_perf_branches);
         end
         if (w_mispredict) begin
            r_perf_mispredicts <= sat_inc(r_perf_mispredicts);
         end
         if (r_state == RECOVER) begin
            r_perf_recover_cycles <= sat_inc(r_perf_recover_cycles);
         end
      end
   end

   assign perf_branches       = r_perf_branches;
   assign perf_mispredicts    = r_perf_mispredicts;
   assign perf_recover_cycles = r_perf_recover_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_ctrl
// Self-checking bench: vector table for single resolves, hand sequences for
// recovery, update back-pressure, queue full, sync error and reset.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_branch_resolve_ctrl;

   logic        CLK;
   logic        RESET;
   logic        pred_valid;
   logic [31:0] pred_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        id_valid;
   logic        id_freeze;
   logic [31:0] id_pc;
   logic        id_is_branch;
   logic        id_taken;
   logic [31:0] id_target;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        upd_valid;
   logic        upd_ready;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        stall;
   logic        q_full;
   logic        sync_err;
`ifdef BRC_PERF_COUNTERS_EN
   logic [31:0] perf_branches;
   logic [31:0] perf_mispredicts;
   logic [31:0] perf_recover_cycles;
`endif

   branch_resolve_ctrl u_dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .pred_valid     (pred_valid),
      .pred_pc        (pred_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .id_valid       (id_valid),
      .id_freeze      (id_freeze),
      .id_pc          (id_pc),
      .id_is_branch   (id_is_branch),
      .id_taken       (id_taken),
      .id_target      (id_target),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .upd_valid      (upd_valid),
      .upd_ready      (upd_ready),
      .upd_pc         (upd_pc),
      .upd_target     (upd_target),
      .upd_taken      (upd_taken),
      .stall          (stall),
      .q_full         (q_full),
      .sync_err       (sync_err)
`ifdef BRC_PERF_COUNTERS_EN
      ,
      .perf_branches       (perf_branches),
      .perf_mispredicts    (perf_mispredicts),
      .perf_recover_cycles (perf_recover_cycles)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] tgt;
   } exp_upd_t;

   typedef struct {
      logic        do_push;
      logic [31:0] p_pc;
      logic        p_taken;
      logic [31:0] p_tgt;
      logic [31:0] r_pc;
      logic        r_br;
      logic        r_taken;
      logic [31:0] r_tgt;
      logic        e_flush;
      logic [31:0] e_redir;
   } vec_t;

   exp_upd_t sb[$];
   exp_upd_t e_mon;
   vec_t     vecs[9];
   int       checks = 0;
   int       errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      pred_valid = 1'b0;
      id_valid   = 1'b0;
      id_freeze  = 1'b0;
   endtask

   task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
      pred_valid  = 1'b1;
      pred_pc     = pc;
      pred_taken  = tk;
      pred_target = tg;
   endtask

   // exp_upd: the bench expects this resolve to reach the update buffer.
   task automatic resolve(input logic [31:0] pc, input logic br, input logic tk,
                          input logic [31:0] tg, input logic exp_upd);
      id_valid     = 1'b1;
      id_pc        = pc;
      id_is_branch = br;
      id_taken     = tk;
      id_target    = tg;
      if (exp_upd) sb.push_back('{pc: pc, taken: tk, tgt: tg});
   endtask

   always @(negedge CLK) begin
      if (RESET && upd_valid && upd_ready) begin
         if (sb.size() == 0) begin
            chk("upd_unexpected", 32'd1, 32'd0);
         end else begin
            e_mon = sb.pop_front();
            chk("upd_pc", upd_pc, e_mon.pc);
            chk("upd_taken", {31'd0, upd_taken}, {31'd0, e_mon.taken});
            chk("upd_target", upd_target, e_mon.tgt);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{1'b1, 32'h0040_0000, 1'b1, 32'h0040_0040, 32'h0040_0000, 1'b1, 1'b1, 32'h0040_0040, 1'b0, 32'h0};
      vecs[1] = '{1'b1, 32'h0040_0010, 1'b0, 32'h0,         32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100};
      vecs[2] = '{1'b1, 32'h0040_0020, 1'b1, 32'h0040_0080, 32'h0040_0020, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0024};
      vecs[3] = '{1'b1, 32'h0040_0050, 1'b0, 32'h0,         32'h0040_0050, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
      vecs[4] = '{1'b1, 32'h0040_0060, 1'b1, 32'h0040_0200, 32'h0040_0060, 1'b1, 1'b1, 32'h0040_0204, 1'b1, 32'h0040_0204};
      vecs[5] = '{1'b1, 32'h0040_0070, 1'b1, 32'h0040_0300, 32'h0040_0070, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0040_0074};
      vecs[6] = '{1'b0, 32'h0,         1'b0, 32'h0,         32'h0040_0090, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
      vecs[7] = '{1'b0, 32'h0,         1'b0, 32'h0,         32'h0040_00A0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0};
      vecs[8] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0010, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000};

      RESET = 1'b0;
      upd_ready = 1'b1;
      pred_pc = '0; pred_taken = 1'b0; pred_target = '0;
      id_pc = '0; id_is_branch = 1'b0; id_taken = 1'b0; id_target = '0;
      idle();
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      chk("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_q_full", {31'd0, q_full}, 32'd0);
      chk("rst_sync_err", {31'd0, sync_err}, 32'd0);
      tick();
      RESET = 1'b1;
      tick();

      // Single push/resolve vectors
      for (int i = 0; i < 9; i++) begin
         if (vecs[i].do_push) push(vecs[i].p_pc, vecs[i].p_taken, vecs[i].p_tgt);
         tick();
         pred_valid = 1'b0;
         resolve(vecs[i].r_pc, vecs[i].r_br, vecs[i].r_taken, vecs[i].r_tgt, vecs[i].r_br);
         tick();
         idle();
         @(negedge CLK);
         chk($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].e_flush});
         chk($sformatf("v%0d_redirect_valid", i), {31'd0, redirect_valid}, {31'd0, vecs[i].e_flush});
         if (vecs[i].e_flush) chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_redir);
         chk($sformatf("v%0d_sync_err", i), {31'd0, sync_err}, 32'd0);
         tick();
         @(negedge CLK);
         chk($sformatf("v%0d_flush_one_cycle", i), {31'd0, flush}, 32'd0);
         repeat (3) tick();
      end

      // Pushes and resolves during RECOVER are ignored
      push(32'h0040_0010, 1'b0, 32'h0);
      tick();
      pred_valid = 1'b0;
      resolve(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100, 1'b1);
      tick();
      id_valid = 1'b0;
      push(32'h0050_0000, 1'b0, 32'h0);
      @(negedge CLK);
      chk("rec_flush", {31'd0, flush}, 32'd1);
      chk("rec_redirect_pc", redirect_pc, 32'h0040_0100);
      tick();
      push(32'h0050_0004, 1'b0, 32'h0);
      resolve(32'h0000_BAD0, 1'b1, 1'b1, 32'h0000_0BAD, 1'b0);
      @(negedge CLK);
      chk("rec_flush_low", {31'd0, flush}, 32'd0);
      tick();
      id_valid = 1'b0;
      push(32'h0040_0104, 1'b0, 32'h0);
      @(negedge CLK);
      chk("rec_ignored_resolve_flush", {31'd0, flush}, 32'd0);
      tick();
      pred_valid = 1'b0;
      resolve(32'h0040_0104, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      idle();
      @(negedge CLK);
      chk("rec_accept_flush", {31'd0, flush}, 32'd0);
      chk("rec_accept_sync", {31'd0, sync_err}, 32'd0);
      tick();

      // Frozen decode does not resolve
      push(32'h0090_0000, 1'b0, 32'h0);
      tick();
      pred_valid = 1'b0;
      resolve(32'h0000_0123, 1'b1, 1'b1, 32'h0, 1'b0);
      id_freeze = 1'b1;
      tick();
      id_freeze = 1'b0;
      resolve(32'h0090_0000, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge CLK);
      chk("frz_flush", {31'd0, flush}, 32'd0);
      tick();
      idle();
      @(negedge CLK);
      chk("frz_after_flush", {31'd0, flush}, 32'd0);
      chk("frz_sync", {31'd0, sync_err}, 32'd0);
      tick();

      // Update buffer back-pressure
      upd_ready = 1'b0;
      resolve(32'h0060_0000, 1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      resolve(32'h0060_0004, 1'b1, 1'b0, 32'h0, 1'b1);
      @(negedge CLK);
      chk("ub_stall_one", {31'd0, stall}, 32'd0);
      tick();
      resolve(32'h0060_0008, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge CLK);
      chk("ub_stall_full", {31'd0, stall}, 32'd1);
      tick();
      idle();
      @(negedge CLK);
      chk("ub_stall_hold", {31'd0, stall}, 32'd1);
      chk("ub_valid", {31'd0, upd_valid}, 32'd1);
      chk("ub_head_pc", upd_pc, 32'h0060_0000);
      tick();
      @(negedge CLK);
      chk("ub_head_stable", upd_pc, 32'h0060_0000);
      tick();
      upd_ready = 1'b1;
      resolve(32'h0060_000C, 1'b1, 1'b0, 32'h0, 1'b1);
      @(negedge CLK);
      chk("ub_stall_drain", {31'd0, stall}, 32'd0);
      tick();
      idle();
      repeat (3) tick();
      @(negedge CLK);
      chk("ub_empty", {31'd0, upd_valid}, 32'd0);
      chk("ub_sb_empty", sb.size(), 32'd0);
      tick();

      // Prediction queue full, extra push dropped
      for (int i = 0; i < 5; i++) begin
         push(32'h0070_0000 + 32'(4 * i), 1'b0, 32'h0);
         tick();
         @(negedge CLK);
         if (i == 2) chk("qf_not_full", {31'd0, q_full}, 32'd0);
         if (i >= 3) chk($sformatf("qf_full_%0d", i), {31'd0, q_full}, 32'd1);
      end
      pred_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         resolve(32'h0070_0000 + 32'(4 * i), 1'b0, 1'b0, 32'h0, 1'b0);
         tick();
         idle();
         @(negedge CLK);
         chk($sformatf("qf_flush_%0d", i), {31'd0, flush}, 32'd0);
         if (i == 0) chk("qf_after_pop", {31'd0, q_full}, 32'd0);
      end
      chk("qf_sync", {31'd0, sync_err}, 32'd0);
      tick();

      // PC desync sets the sticky error
      push(32'h0040_0034, 1'b0, 32'h0);
      tick();
      pred_valid = 1'b0;
      resolve(32'h0040_0030, 1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      idle();
      @(negedge CLK);
      chk("se_flush", {31'd0, flush}, 32'd1);
      chk("se_redirect_pc", redirect_pc, 32'h0040_0034);
      chk("se_sync_err", {31'd0, sync_err}, 32'd1);
      repeat (3) tick();
      resolve(32'h0040_0500, 1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      idle();
      @(negedge CLK);
      chk("se_sticky", {31'd0, sync_err}, 32'd1);
      chk("se_no_flush", {31'd0, flush}, 32'd0);
      tick();

      // Reset in the middle of RECOVER
      push(32'h0080_0000, 1'b0, 32'h0);
      tick();
      pred_valid = 1'b0;
      resolve(32'h0080_0000, 1'b1, 1'b1, 32'h0080_0100, 1'b0);
      upd_ready = 1'b0;
      tick();
      idle();
      @(negedge CLK);
      chk("mr_flush", {31'd0, flush}, 32'd1);
      chk("mr_upd_valid", {31'd0, upd_valid}, 32'd1);
      RESET = 1'b0;
      sb.delete();
      #1;
      chk("mr_rst_flush", {31'd0, flush}, 32'd0);
      chk("mr_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      chk("mr_rst_redirect_pc", redirect_pc, 32'd0);
      chk("mr_rst_upd_valid", {31'd0, upd_valid}, 32'd0);
      chk("mr_rst_upd_pc", upd_pc, 32'd0);
      chk("mr_rst_upd_target", upd_target, 32'd0);
      chk("mr_rst_upd_taken", {31'd0, upd_taken}, 32'd0);
      chk("mr_rst_stall", {31'd0, stall}, 32'd0);
      chk("mr_rst_q_full", {31'd0, q_full}, 32'd0);
      chk("mr_rst_sync_err", {31'd0, sync_err}, 32'd0);
      tick();
      RESET = 1'b1;
      upd_ready = 1'b1;
      push(32'h0080_0200, 1'b1, 32'h0080_0300);
      tick();
      pred_valid = 1'b0;
      resolve(32'h0080_0200, 1'b1, 1'b1, 32'h0080_0300, 1'b1);
      tick();
      idle();
      @(negedge CLK);
      chk("mr_push_after_reset", {31'd0, flush}, 32'd0);
      tick();

      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      chk("sb_drain", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
